// File: rtl/ext_fogzip_decoder.sv
// FogZip decoder: fetches a pre-order occupancy stream over EXT_MEM,
// walks the octree depth-first and emits one point per occupied leaf.
module ext_fogzip_decoder #(
  parameter logic [31:0]        BASE_ADDR      = 32'd0,
  parameter int                 MAX_DEPTH      = 9,
  parameter int                 ROOT_SIZE_LOG2 = 16,
  parameter logic signed [15:0] BB_MIN_X       = -16'sd20000,
  parameter logic signed [15:0] BB_MIN_Y       = -16'sd20000,
  parameter logic signed [15:0] BB_MIN_Z       = -16'sd20000,
  parameter int                 MAX_READ_WORDS = 65536
) (
  input  logic        i_SYSTEM_clk,
  input  logic        i_SYSTEM_rst,
  input  logic        EXT_enable,
  output logic        EXT_doneProcessing,
  output logic [31:0] EXT_status,
  output logic        EXT_writeValid,
  input  logic        EXT_writeReady,
  output logic [18:0] EXT_writeID,
  output logic [15:0] EXT_writePointX,
  output logic [15:0] EXT_writePointY,
  output logic [15:0] EXT_writePointZ,
  output logic [31:0] EXT_MEM_readAddress,
  output logic        EXT_MEM_initReadTxn,
  input  logic [63:0] EXT_MEM_readPayload,
  input  logic        EXT_MEM_readTxnDone,
  input  logic        EXT_MEM_error
);

  localparam int DW = $clog2(MAX_DEPTH + 1);
  localparam logic [DW-1:0] LEAF_SP = DW'(MAX_DEPTH);
  localparam logic [15:0] LEAF_HALF =
    (ROOT_SIZE_LOG2 > MAX_DEPTH) ?
    16'(1 << (ROOT_SIZE_LOG2 - MAX_DEPTH - 1)) : 16'd0;

  typedef enum logic [3:0] {
    S_IDLE, S_HDR, S_FETCH, S_MEMW, S_PUSH,
    S_SCAN, S_EMIT, S_GAP, S_POP, S_ERR, S_DONE
  } state_t;

  state_t      state;
  logic        en_q;
  logic [DW-1:0] sp;
  logic [7:0]  st_mask [MAX_DEPTH];
  logic [15:0] st_x [MAX_DEPTH];
  logic [15:0] st_y [MAX_DEPTH];
  logic [15:0] st_z [MAX_DEPTH];
  logic [15:0] cur_x, cur_y, cur_z;
  logic [63:0] buf_q;
  logic [2:0]  bp;
  logic        buf_vld;
  logic [7:0]  byte_q;
  logic [31:0] rd_cnt;
  logic [31:0] rd_addr;
  logic [18:0] hdr_cnt;
  logic [18:0] pt_cnt;
  logic        f_busy, f_done, f_mem, f_zero, f_mis, f_rlim;

  logic [DW-1:0] top;
  logic [7:0]    top_mask;
  logic [2:0]    k;
  logic [4:0]    sh;
  logic [15:0]   step;
  logic [15:0]   cx, cy, cz;
  logic [7:0]    cur_byte;
  logic          leaf;

  assign top      = sp - DW'(1);
  assign cur_byte = buf_q[{bp, 3'b000} +: 8];
  assign leaf     = (sp == LEAF_SP);

  // Child of the top-of-stack node selected by its lowest set mask bit
  always_comb begin
    top_mask = st_mask[top];
    k = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (top_mask[i]) k = 3'(i);
    end
    sh   = 5'(ROOT_SIZE_LOG2 - 1) - 5'(top);
    step = 16'd1 << sh;
    cx   = st_x[top] + (k[0] ? step : 16'd0);
    cy   = st_y[top] + (k[1] ? step : 16'd0);
    cz   = st_z[top] + (k[2] ? step : 16'd0);
  end

  assign EXT_doneProcessing  = f_done;
  assign EXT_writeID         = pt_cnt;
  assign EXT_MEM_readAddress = rd_addr;
  assign EXT_status = {pt_cnt, 7'd0, f_rlim, f_mis,
                       f_zero, f_mem, f_done, f_busy};

  always_ff @(posedge i_SYSTEM_clk or negedge i_SYSTEM_rst) begin
    if (!i_SYSTEM_rst) begin
      state   <= S_IDLE;
      en_q    <= 1'b0;
      sp      <= '0;
      for (int i = 0; i < MAX_DEPTH; i++) begin
        st_mask[i] <= '0;
        st_x[i]    <= '0;
        st_y[i]    <= '0;
        st_z[i]    <= '0;
      end
      cur_x   <= '0;
      cur_y   <= '0;
      cur_z   <= '0;
      buf_q   <= '0;
      bp      <= '0;
      buf_vld <= 1'b0;
      byte_q  <= '0;
      rd_cnt  <= '0;
      rd_addr <= '0;
      hdr_cnt <= '0;
      pt_cnt  <= '0;
      f_busy  <= 1'b0;
      f_done  <= 1'b0;
      f_mem   <= 1'b0;
      f_zero  <= 1'b0;
      f_mis   <= 1'b0;
      f_rlim  <= 1'b0;
      EXT_writeValid      <= 1'b0;
      EXT_writePointX     <= '0;
      EXT_writePointY     <= '0;
      EXT_writePointZ     <= '0;
      EXT_MEM_initReadTxn <= 1'b0;
    end else begin
      en_q <= EXT_enable;
      EXT_MEM_initReadTxn <= 1'b0;
      if (state != S_IDLE && !EXT_enable) begin
        state          <= S_IDLE;
        sp             <= '0;
        buf_vld        <= 1'b0;
        pt_cnt         <= '0;
        EXT_writeValid <= 1'b0;
        f_busy <= 1'b0;
        f_done <= 1'b0;
        f_mem  <= 1'b0;
        f_zero <= 1'b0;
        f_mis  <= 1'b0;
        f_rlim <= 1'b0;
      end else if (EXT_MEM_error && state != S_IDLE &&
                   state != S_DONE && state != S_ERR) begin
        // Wins over a same-cycle readTxnDone; any pending read is dropped
        f_mem          <= 1'b1;
        EXT_writeValid <= 1'b0;
        state          <= S_ERR;
      end else begin
        unique case (state)
          S_IDLE: begin
            if (EXT_enable && !en_q) begin
              state   <= S_HDR;
              EXT_MEM_initReadTxn <= 1'b1;
              rd_addr <= BASE_ADDR;
              rd_cnt  <= 32'd1;
              sp      <= '0;
              buf_vld <= 1'b0;
              pt_cnt  <= '0;
              cur_x   <= BB_MIN_X;
              cur_y   <= BB_MIN_Y;
              cur_z   <= BB_MIN_Z;
              f_busy  <= 1'b1;
            end
          end
          S_HDR: begin
            if (EXT_MEM_readTxnDone) begin
              hdr_cnt <= EXT_MEM_readPayload[18:0];
              rd_addr <= rd_addr + 32'd8;
              state   <= S_FETCH;
            end
          end
          S_FETCH: begin
            if (!buf_vld) begin
              if (rd_cnt >= 32'(MAX_READ_WORDS)) begin
                f_rlim <= 1'b1;
                state  <= S_ERR;
              end else begin
                EXT_MEM_initReadTxn <= 1'b1;
                rd_cnt <= rd_cnt + 32'd1;
                state  <= S_MEMW;
              end
            end else begin
              byte_q <= cur_byte;
              bp     <= bp + 3'd1;
              if (bp == 3'd7) buf_vld <= 1'b0;
              if (cur_byte == 8'd0) begin
                f_zero <= 1'b1;
                state  <= S_ERR;
              end else begin
                state <= S_PUSH;
              end
            end
          end
          S_MEMW: begin
            if (EXT_MEM_readTxnDone) begin
              buf_q   <= EXT_MEM_readPayload;
              bp      <= 3'd0;
              buf_vld <= 1'b1;
              rd_addr <= rd_addr + 32'd8;
              state   <= S_FETCH;
            end
          end
          S_PUSH: begin
            st_mask[sp] <= byte_q;
            st_x[sp]    <= cur_x;
            st_y[sp]    <= cur_y;
            st_z[sp]    <= cur_z;
            sp          <= sp + DW'(1);
            state       <= S_SCAN;
          end
          S_SCAN: begin
            if (top_mask == 8'd0) begin
              state <= S_POP;
            end else begin
              st_mask[top] <= top_mask & ~(8'd1 << k);
              if (leaf) begin
                EXT_writePointX <= cx + LEAF_HALF;
                EXT_writePointY <= cy + LEAF_HALF;
                EXT_writePointZ <= cz + LEAF_HALF;
                EXT_writeValid  <= 1'b1;
                state           <= S_EMIT;
              end else begin
                cur_x <= cx;
                cur_y <= cy;
                cur_z <= cz;
                state <= S_FETCH;
              end
            end
          end
          S_EMIT: begin
            if (EXT_writeReady) begin
              EXT_writeValid <= 1'b0;
              pt_cnt         <= pt_cnt + 19'd1;
              state          <= S_GAP;
            end
          end
          S_GAP: state <= S_SCAN;
          S_POP: begin
            sp <= sp - DW'(1);
            if (sp == DW'(1)) begin
              f_done <= 1'b1;
              f_busy <= 1'b0;
              f_mis  <= (pt_cnt != hdr_cnt);
              state  <= S_DONE;
            end else begin
              state <= S_SCAN;
            end
          end
          S_ERR: begin
            f_done <= 1'b1;
            f_busy <= 1'b0;
            state  <= S_DONE;
          end
          S_DONE: state <= S_DONE;
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule
